// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start, data LSB first, optional parity, stop.
// One word per valid/ready handshake; every output is a flop.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam bit HAS_PAR = (PARITY_EN != 0);
  localparam bit ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              accept;

  assign bit_end = (cnt_q == CNT_LAST);
  assign accept  = DIN_VALID & rdy_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        rdy_d  = 1'b1;
        if (accept) begin
          sh_d    = DIN;
          par_d   = (^DIN) ^ ODD;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (HAS_PAR) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        // Corrupted encoding: park on an idle line.
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  assign DIN_READY = rdy_q;
  assign TX_OUT    = tx_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule
